// File: rtl/mc_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB sequencer, 16-entry register file, req/ack memory ports.
// Optional feature macro: CORE_MUL_EN enables opcode 11 (MUL); undefined leaves it illegal.
module mc_core #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 13,
  parameter int DADDR_W = 13
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [15:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               retire,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4, OP_SLT = 4'h5, OP_LDI = 4'h6, OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8, OP_BEQZ = 4'h9, OP_JMP = 4'hA, OP_MUL = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             state_r, state_n;
  logic [PC_W-1:0]    pc_r;
  logic [15:0]        ir_r;
  logic [DATA_W-1:0]  a_r, b_r, d_r, res_r;
  logic [DATA_W-1:0]  rf_r [16];
  logic               imem_req_r, dmem_req_r, dmem_we_r, halted_r, illegal_r;
  logic [DADDR_W-1:0] dmem_addr_r;
  logic [DATA_W-1:0]  dmem_wdata_r;
  logic [DATA_W-1:0]  alu_s;
  logic               retire_s, slt_s;
  logic [3:0]         op_s, rd_s, rs_s, rt_s;
  logic [7:0]         imm8_s;
  logic [11:0]        imm12_s;
  logic [PC_W-1:0]    pc_inc_s, br_target_s, jmp_target_s;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_LDI,
      OP_LD, OP_ST, OP_BEQZ, OP_JMP, OP_HALT: ok = 1'b1;
`ifdef CORE_MUL_EN
      OP_MUL: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign op_s         = ir_r[15:12];
  assign rd_s         = ir_r[11:8];
  assign rs_s         = ir_r[7:4];
  assign rt_s         = ir_r[3:0];
  assign imm8_s       = ir_r[7:0];
  assign imm12_s      = ir_r[11:0];
  assign slt_s        = $signed(a_r) < $signed(b_r);
  assign pc_inc_s     = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  // pc_r already points past the branch when EXEC runs
  assign br_target_s  = pc_r + PC_W'($signed(imm8_s));
  assign jmp_target_s = PC_W'(imm12_s);

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wdata = dmem_wdata_r;
  assign retire     = retire_s;
  assign halted     = halted_r;
  assign illegal    = illegal_r;

  // ALU result for register-writing opcodes
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (op_s)
      OP_ADD: alu_s = a_r + b_r;
      OP_SUB: alu_s = a_r - b_r;
      OP_AND: alu_s = a_r & b_r;
      OP_OR:  alu_s = a_r | b_r;
      OP_XOR: alu_s = a_r ^ b_r;
      OP_SLT: alu_s = {{(DATA_W-1){1'b0}}, slt_s};
      OP_LDI: alu_s = DATA_W'($signed(imm8_s));
`ifdef CORE_MUL_EN
      OP_MUL: alu_s = a_r * b_r;
`endif
      default: alu_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state and retire decode
  always_comb begin
    state_n  = state_r;
    retire_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (imem_req_r && imem_ack) state_n = S_DECODE;
        else                        state_n = S_FETCH;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (!op_legal(op_s)) begin
          state_n = S_HALT;
        end else begin
          case (op_s)
            OP_LD, OP_ST:    state_n = S_MEM;
            OP_BEQZ, OP_JMP: begin
              state_n  = S_FETCH;
              retire_s = 1'b1;
            end
            OP_HALT: state_n = S_HALT;
            default: state_n = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_req_r && dmem_ack) begin
          if (op_s == OP_LD) begin
            state_n = S_WB;
          end else begin
            state_n  = S_FETCH;
            retire_s = 1'b1;
          end
        end else begin
          state_n = S_MEM;
        end
      end
      S_WB: begin
        state_n  = S_FETCH;
        retire_s = 1'b1;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // Control state and registered request/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      halted_r   <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      imem_req_r <= (state_n == S_FETCH);
      dmem_req_r <= (state_n == S_MEM);
      halted_r   <= (state_n == S_HALT);
      if (state_r == S_EXEC && !op_legal(op_s)) illegal_r <= 1'b1;
    end
  end

  // Program counter and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= {PC_W{1'b0}};
      ir_r <= 16'h0000;
    end else if (state_r == S_FETCH && imem_req_r && imem_ack) begin
      ir_r <= imem_rdata;
      pc_r <= pc_inc_s;
    end else if (state_r == S_EXEC && op_s == OP_BEQZ && d_r == {DATA_W{1'b0}}) begin
      pc_r <= br_target_s;
    end else if (state_r == S_EXEC && op_s == OP_JMP) begin
      pc_r <= jmp_target_s;
    end
  end

  // Operand latch, result register and data-port request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      d_r          <= {DATA_W{1'b0}};
      res_r        <= {DATA_W{1'b0}};
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= {DADDR_W{1'b0}};
      dmem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      if (state_r == S_DECODE) begin
        a_r <= rf_r[rs_s];
        b_r <= rf_r[rt_s];
        d_r <= rf_r[rd_s];
      end
      if (state_r == S_EXEC) begin
        res_r <= alu_s;
        if (op_s == OP_LD || op_s == OP_ST) begin
          dmem_we_r    <= (op_s == OP_ST);
          dmem_addr_r  <= DADDR_W'(a_r);
          dmem_wdata_r <= b_r;
        end
      end
      if (state_r == S_MEM && dmem_req_r && dmem_ack && op_s == OP_LD) res_r <= dmem_rdata;
    end
  end

  // Register file; R0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_r[i] <= {DATA_W{1'b0}};
    end else if (state_r == S_WB && rd_s != 4'h0) begin
      rf_r[rd_s] <= res_r;
    end
  end

endmodule
